// File: rtl/tft_address_generator_if.sv
// Pixel request / address response bundle for tft_address_generator.
// The master drives the coordinate request. The slave returns the registered address and flags.
interface tft_address_generator_if #(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 9,
  parameter int unsigned AW = 18
);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          in_valid;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic          addr_last;
  logic          out_of_range;

  modport master (
    output x, y, in_valid,
    input  addr, addr_valid, addr_last, out_of_range
  );

  modport slave (
    input  x, y, in_valid,
    output addr, addr_valid, addr_last, out_of_range
  );
endinterface

// File: rtl/tft_address_generator.sv
// Column-major frame-buffer address generator: addr = x*V_ACTIVE + y, one-cycle latency.
// Optional macro TFT_ADDR_RANGE_CHECK_EN flags coordinates outside the active area and
// suppresses the address for them. When the macro is undefined, out_of_range is tied low
// and any coordinate produces the truncated product-sum.
module tft_address_generator #(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned XW       = 9,
  parameter int unsigned YW       = 9,
  parameter int unsigned AW       = 18
) (
  input logic clk,
  input logic rst,
  tft_address_generator_if.slave bus
);

  localparam int unsigned SW = AW + 1;

  logic [SW-1:0] prod;
  logic [SW-1:0] sum;
  logic [AW-1:0] addr_next;
  logic          last_next;
  logic          unused_carry;

  // The x*V_ACTIVE term uses shift-add when V_ACTIVE is the default 272 = 256 + 16.
  generate
    if (V_ACTIVE == 272) begin : g_shift_add
      assign prod = (SW'(bus.x) << 8) + (SW'(bus.x) << 4);
    end else begin : g_const_mult
      assign prod = SW'(bus.x) * SW'(V_ACTIVE);
    end
  endgenerate

  assign sum          = prod + SW'(bus.y);
  assign addr_next    = sum[AW-1:0];
  assign unused_carry = sum[AW];
  assign last_next    = (bus.x == XW'(H_ACTIVE - 1)) && (bus.y == YW'(V_ACTIVE - 1));

  logic [AW-1:0] addr_q;
  logic          addr_valid_q;
  logic          addr_last_q;

`ifdef TFT_ADDR_RANGE_CHECK_EN
  logic in_range;
  logic out_of_range_q;

  // Widen by one bit so that the comparison is correct even when H_ACTIVE or V_ACTIVE equals 2**width.
  assign in_range = ({1'b0, bus.x} < (XW+1)'(H_ACTIVE)) &&
                    ({1'b0, bus.y} < (YW+1)'(V_ACTIVE));

  // Output register. Reset wins over a request on the same edge.
  // An out-of-range request zeroes addr and raises out_of_range.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      addr_valid_q   <= 1'b0;
      addr_last_q    <= 1'b0;
      out_of_range_q <= 1'b0;
    end else if (bus.in_valid) begin
      if (in_range) begin
        addr_q         <= addr_next;
        addr_valid_q   <= 1'b1;
        addr_last_q    <= last_next;
        out_of_range_q <= 1'b0;
      end else begin
        addr_q         <= '0;
        addr_valid_q   <= 1'b0;
        addr_last_q    <= 1'b0;
        out_of_range_q <= 1'b1;
      end
    end else begin
      addr_valid_q   <= 1'b0;
      addr_last_q    <= 1'b0;
      out_of_range_q <= 1'b0;
    end
  end

  assign bus.out_of_range = out_of_range_q;
`else
  // Output register. Reset wins over a request on the same edge. addr holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
    end else if (bus.in_valid) begin
      addr_q       <= addr_next;
      addr_valid_q <= 1'b1;
      addr_last_q  <= last_next;
    end else begin
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
    end
  end

  assign bus.out_of_range = 1'b0;
`endif

  assign bus.addr       = addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.addr_last  = addr_last_q;

endmodule

// File: tb/tb_tft_address_generator.sv
// Directed self-checking bench for tft_address_generator. Define TFT_ADDR_RANGE_CHECK_EN to
// exercise the range-check build.
module tb_tft_address_generator;

  localparam int unsigned H_ACTIVE = 480;
  localparam int unsigned V_ACTIVE = 272;
  localparam int unsigned XW       = 9;
  localparam int unsigned YW       = 9;
  localparam int unsigned AW       = 18;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  tft_address_generator_if #(.XW(XW), .YW(YW), .AW(AW)) bus ();

  tft_address_generator #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .XW(XW), .YW(YW), .AW(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven on the falling edge. Outputs are sampled 1 ns after the rising edge that captured them.
  task automatic cycle(input int xv, input int yv, input logic v);
    @(negedge clk);
    bus.x        = XW'(xv);
    bus.y        = YW'(yv);
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int a, input int av, input int al, input int oor);
    chk({tag, ".addr"},         int'(bus.addr),         a);
    chk({tag, ".addr_valid"},   int'(bus.addr_valid),   av);
    chk({tag, ".addr_last"},    int'(bus.addr_last),    al);
    chk({tag, ".out_of_range"}, int'(bus.out_of_range), oor);
  endtask

  initial begin
    int xs[6];
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.x        = '0;
    bus.y        = '0;
    bus.in_valid = 1'b0;

    // A request held during reset is discarded.
    for (int i = 0; i < 3; i++) begin
      cycle(5, 5, 1'b1);
      chk_all("reset", 0, 0, 0, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Boundary points. The first request after reset appears one cycle later.
    cycle(0, 0, 1'b1);     chk_all("p0_0",     0,      1, 0, 0);
    cycle(0, 271, 1'b1);   chk_all("p0_271",   271,    1, 0, 0);
    cycle(1, 0, 1'b1);     chk_all("p1_0",     272,    1, 0, 0);
    cycle(479, 271, 1'b1); chk_all("p479_271", 130559, 1, 1, 0);

    // Valid gating: addr holds while idle.
    cycle(2, 3, 1'b1);     chk_all("gate1", 547,  1, 0, 0);
    cycle(9, 9, 1'b0);     chk_all("gate0", 547,  0, 0, 0);
    cycle(4, 0, 1'b1);     chk_all("gate2", 1088, 1, 0, 0);

    // Full columns at selected x, including the wrap 271 -> next column and the final pixel.
    xs = '{0, 1, 2, 137, 478, 479};
    foreach (xs[k]) begin
      for (int yy = 0; yy < 272; yy++) begin
        cycle(xs[k], yy, 1'b1);
        chk("col.addr", int'(bus.addr), xs[k] * 272 + yy);
        chk("col.addr_last", int'(bus.addr_last), (xs[k] == 479 && yy == 271) ? 1 : 0);
      end
    end

    // Every column at the top and bottom rows.
    for (int xx = 0; xx < 480; xx++) begin
      cycle(xx, 0, 1'b1);
      chk("row0.addr", int'(bus.addr), xx * 272);
      cycle(xx, 271, 1'b1);
      chk("row271.addr", int'(bus.addr), xx * 272 + 271);
      chk("row271.addr_last", int'(bus.addr_last), (xx == 479) ? 1 : 0);
    end

    // Range handling.
`ifdef TFT_ADDR_RANGE_CHECK_EN
    cycle(480, 0, 1'b1);   chk_all("oor_x",  0,      0, 0, 1);
    cycle(0, 272, 1'b1);   chk_all("oor_y",  0,      0, 0, 1);
    cycle(479, 271, 1'b1); chk_all("in_max", 130559, 1, 1, 0);
    cycle(0, 0, 1'b0);     chk_all("idle",   130559, 0, 0, 0);
`else
    cycle(480, 0, 1'b1);   chk_all("nochk_x", 130560, 1, 0, 0);
    cycle(0, 272, 1'b1);   chk_all("nochk_y", 272,    1, 0, 0);
`endif

    // Reset mid-stream wins over a valid request.
    @(negedge clk);
    rst = 1'b1;
    cycle(3, 3, 1'b1);     chk_all("rst_mid", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cycle(3, 3, 1'b1);     chk_all("post_rst", 819, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
